// File: rtl/add_const_pipe_if.sv
// rtl/add_const_pipe_if.sv - handshake bundle for add_const_pipe
// slave is the pipeline side, master is the producer/consumer side.
interface add_const_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ovf;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf, occupancy
  );
endinterface

// File: rtl/add_const_pipe.sv
// rtl/add_const_pipe.sv - elastic DEPTH-stage pipeline adding INC, wrap or saturate
// Define ADD_CONST_PIPE_ASSERT_EN to compile in protocol properties.
module add_const_pipe #(
  parameter int          WIDTH = 32,
  parameter int          DEPTH = 2,
  parameter int unsigned INC   = 5,
  parameter bit          SAT   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  add_const_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ovf_q;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic [OCC_W-1:0] occ;

  assign sum = {1'b0, bus.in_data} + (WIDTH + 1)'(INC);
  assign res = (SAT && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  // A stage moves when any stage from it to the output has a hole, or the sink takes a beat.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = bus.out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!vld[j]) adv[i] = 1'b1;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(vld[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      ovf_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld[0] <= bus.in_valid;
        if (bus.in_valid) begin
          dat[0]   <= res;
          ovf_q[0] <= sum[WIDTH];
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i]   <= dat[i-1];
            ovf_q[i] <= ovf_q[i-1];
          end
        end
      end
    end
  end

  // in_ready is forced low combinationally so it is 0 for the whole reset pulse.
  assign bus.in_ready  = !rst && adv[0];
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];
  assign bus.ovf       = ovf_q[DEPTH-1];
  assign bus.occupancy = occ;

`ifdef ADD_CONST_PIPE_ASSERT_EN
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.ovf)));

  a_occ_bound: assert property (@(posedge clk) bus.occupancy <= OCC_W'(DEPTH));

  a_rst_quiet: assert property (@(posedge clk) rst |-> !bus.out_valid);

  a_full_block: assert property (@(posedge clk) disable iff (rst)
    (bus.occupancy == OCC_W'(DEPTH) && !bus.out_ready) |-> !bus.in_ready);
`else
  // Default build carries no checking logic.
`endif
endmodule
